// File: rtl/conv_seq_controller.sv
// conv_seq_controller: sequences a valid-mode KxK convolution walk, waits out MAC latency, hands off each result
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, abort               frame start pulse (IDLE only), soft cancel
//   valid_in / in_ready        tap handshake from the window feeder
//   mac_en, acc_clear, tap_idx MAC array controls and current tap index
//   out_valid / out_ready      result handshake to the writer, tagged by out_row/out_col
//   busy, done                 frame activity and one-cycle completion pulse
module conv_seq_controller #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int K = 3,
  parameter int MAC_LAT = 2,
  localparam int NT = K * K,
  localparam int TW = NT > 1 ? $clog2(NT) : 1,
  localparam int RW = (IMG_H - K + 1) > 1 ? $clog2(IMG_H - K + 1) : 1,
  localparam int CW = (IMG_W - K + 1) > 1 ? $clog2(IMG_W - K + 1) : 1,
  localparam int DW = MAC_LAT > 1 ? $clog2(MAC_LAT) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          valid_in,
  output logic          in_ready,
  output logic          mac_en,
  output logic          acc_clear,
  output logic [TW-1:0] tap_idx,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          busy,
  output logic          done
);
  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, OUTPUT, DONE} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] tap_q, tap_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [DW-1:0] drn_q, drn_d;
  logic last_tap, last_col, last_row, drn_last;
  assign last_tap = tap_q == TW'(NT - 1);
  assign last_col = col_q == CW'(IMG_W - K);
  assign last_row = row_q == RW'(IMG_H - K);
  assign drn_last = drn_q == DW'(MAC_LAT - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tap_q <= '0;
      row_q <= '0;
      col_q <= '0;
      drn_q <= '0;
    end else begin
      state_q <= state_d;
      tap_q <= tap_d;
      row_q <= row_d;
      col_q <= col_d;
      drn_q <= drn_d;
    end
  end
  // abort outranks everything; in IDLE the counters are already zero, so it is a no-op there
  always_comb begin
    state_d = state_q;
    tap_d = tap_q;
    row_d = row_q;
    col_d = col_q;
    drn_d = drn_q;
    if (abort) begin
      state_d = IDLE;
      tap_d = '0;
      row_d = '0;
      col_d = '0;
      drn_d = '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = ACCUM;
          tap_d = '0;
          row_d = '0;
          col_d = '0;
        end
        ACCUM: if (valid_in) begin
          tap_d = last_tap ? '0 : tap_q + 1'b1;
          if (last_tap) state_d = MAC_LAT == 0 ? OUTPUT : DRAIN;
        end
        DRAIN: begin
          drn_d = drn_last ? '0 : drn_q + 1'b1;
          if (drn_last) state_d = OUTPUT;
        end
        OUTPUT: if (out_ready) begin
          if (last_row && last_col) state_d = DONE;
          else begin
            state_d = ACCUM;
            col_d = last_col ? '0 : col_q + 1'b1;
            row_d = last_col ? row_q + 1'b1 : row_q;
          end
        end
        DONE: begin
          state_d = IDLE;
          row_d = '0;
          col_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  assign in_ready = state_q == ACCUM;
  assign mac_en = valid_in & in_ready;
  assign acc_clear = mac_en & (tap_q == '0);
  assign tap_idx = tap_q;
  assign out_valid = state_q == OUTPUT;
  assign out_row = row_q;
  assign out_col = col_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_conv_seq_controller.sv
// tb_conv_seq_controller: randomized frame-level checks of conv_seq_controller against a transaction model
module tb_conv_seq_controller;
  localparam int W = 5, H = 5, K = 3, LAT = 2;
  localparam int OW = W - K + 1, OH = H - K + 1, NW = OW * OH, NT = K * K;
  logic clk = 1'b0, rst_n;
  logic start, abort, valid_in, out_ready;
  logic in_ready, mac_en, acc_clear, out_valid, busy, done;
  logic [3:0] tap_idx;
  logic [1:0] out_row, out_col;
  logic start1, abort1, valid_in1, out_ready1;
  logic in_ready1, mac_en1, acc_clear1, out_valid1, busy1, done1;
  logic [3:0] tap_idx1;
  logic [1:0] out_row1, out_col1;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  conv_seq_controller #(.IMG_W(W), .IMG_H(H), .K(K), .MAC_LAT(LAT)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .valid_in(valid_in),
    .in_ready(in_ready), .mac_en(mac_en), .acc_clear(acc_clear), .tap_idx(tap_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_col(out_col),
    .busy(busy), .done(done));
  conv_seq_controller #(.IMG_W(W), .IMG_H(H), .K(K), .MAC_LAT(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .valid_in(valid_in1),
    .in_ready(in_ready1), .mac_en(mac_en1), .acc_clear(acc_clear1), .tap_idx(tap_idx1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_row(out_row1), .out_col(out_col1),
    .busy(busy1), .done(done1));
  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_tap"}, tap_idx, 0);
    check({tag, "_row"}, out_row, 0);
    check({tag, "_col"}, out_col, 0);
  endtask
  // Frame model: windows in raster order, K*K taps each, result ready LAT+1 cycles after the last tap
  task automatic run_frame(input int pv, input int pr, input bit do_abort, input bit do_hold);
    int tiw = 0, wins = 0, taps = 0, clears = 0, last_cyc = -1000, hold = 0;
    bit accum = 0, pend = 0, fin = 0, ab = 0, act = 0, ended = 0, exp_ov, exp_mac;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      start = n == 0 ? 1'b1 : $urandom_range(0, 7) == 0;
      valid_in = $urandom_range(0, 99) < pv;
      out_ready = $urandom_range(0, 99) < pr;
      exp_ov = pend && n >= last_cyc + 1 + LAT;
      if (do_hold && wins == 4 && exp_ov && hold < 5) begin
        out_ready = 1'b0;
        hold++;
      end
      abort = do_abort && accum && wins == 2 && tiw == 4;
      exp_mac = valid_in && accum;
      #1;
      check("busy", busy, act);
      check("in_ready", in_ready, accum);
      check("out_valid", out_valid, exp_ov);
      check("done", done, fin);
      check("mac_en", mac_en, exp_mac);
      clears += acc_clear;
      if (exp_mac) begin
        check("tap_idx", tap_idx, tiw);
        check("acc_clear", acc_clear, tiw == 0);
      end
      if (exp_ov) begin
        check("out_row", out_row, wins / OW);
        check("out_col", out_col, wins % OW);
      end
      if (abort) begin
        ab = 1;
        ended = 1;
        break;
      end
      if (fin) begin
        ended = 1;
        break;
      end
      if (n == 0) begin
        act = 1;
        accum = 1;
      end else begin
        if (exp_mac) begin
          taps++;
          tiw++;
          if (tiw == NT) begin
            tiw = 0;
            accum = 0;
            pend = 1;
            last_cyc = n;
          end
        end
        if (exp_ov && out_ready) begin
          pend = 0;
          wins++;
          if (wins == NW) fin = 1;
          else accum = 1;
        end
      end
    end
    if (!ended) check("timeout", 0, 1);
    @(negedge clk);
    start = 0;
    abort = 0;
    valid_in = 0;
    out_ready = 0;
    #1;
    check_idle(ab ? "post_abort" : "post_frame");
    if (!ab) begin
      check("windows", wins, NW);
      check("taps", taps, NW * NT);
      check("clears", clears, NW);
    end
    if (do_hold) check("hold_cycles", hold, 5);
  endtask
  initial begin
    int m, lat, last;
    rst_n = 0;
    start = 0;
    abort = 0;
    valid_in = 1;
    out_ready = 1;
    start1 = 0;
    abort1 = 0;
    valid_in1 = 0;
    out_ready1 = 0;
    #12;
    check_idle("reset");
    check("reset_mac_en", mac_en, 0);
    check("reset_acc_clear", acc_clear, 0);
    @(negedge clk);
    rst_n = 1;
    valid_in = 0;
    out_ready = 0;
    run_frame(100, 100, 0, 0);
    run_frame(100, 100, 0, 1);
    run_frame(50, 100, 0, 0);
    run_frame(60, 60, 1, 0);
    run_frame(100, 100, 0, 0);
    repeat (3) run_frame(70, 70, 0, 1);
    @(negedge clk);
    start = 1;
    abort = 1;
    @(negedge clk);
    start = 0;
    abort = 0;
    #1;
    check_idle("start_abort");
    @(negedge clk);
    start = 1;
    valid_in = 1;
    out_ready = 1;
    @(negedge clk);
    start = 0;
    m = 0;
    for (int n = 0; n < 100 && m < 2 * NT; n++) begin
      #1;
      if (mac_en) m++;
      @(negedge clk);
    end
    #1;
    check("drain_busy", busy, 1);
    check("drain_in_ready", in_ready, 0);
    check("drain_col", out_col, 1);
    rst_n = 0;
    #1;
    check_idle("async_rst");
    check("async_rst_mac_en", mac_en, 0);
    @(negedge clk);
    rst_n = 1;
    valid_in = 0;
    out_ready = 0;
    run_frame(80, 80, 0, 0);
    @(negedge clk);
    start1 = 1;
    valid_in1 = 1;
    lat = -1;
    last = -1;
    for (int n = 0; n < 60; n++) begin
      #1;
      if (mac_en1) last = n;
      if (out_valid1) begin
        lat = n - last;
        break;
      end
      @(negedge clk);
      start1 = 0;
    end
    check("lat0", lat, 1);
    check("lat0_row", out_row1, 0);
    check("lat0_col", out_col1, 0);
    @(negedge clk);
    abort1 = 1;
    @(negedge clk);
    abort1 = 0;
    #1;
    check("lat0_abort_busy", busy1, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/conv_seq_controller.md
Name: conv_seq_controller

Overview:
- Parametrised sequencing controller for the convolution core; successor to the two-state IDLE/PROCESS MAC enable controller.
- Walks a valid-mode KxK convolution over an IMG_W x IMG_H feature map and counts kernel taps per output pixel.
- Waits out the MAC pipeline latency, then presents each result with a valid/ready handshake.
- Sits between the line-buffer/window feeder upstream and the result writer downstream, and drives the MAC array enables.

Parameters:
IMG_W, 8, input feature-map width in pixels (>= K)
IMG_H, 8, input feature-map height in pixels (>= K)
K, 3, kernel edge; K*K taps per output pixel (K >= 1)
MAC_LAT, 2, MAC pipeline latency in cycles from last tap to result valid (>= 0)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that begins a frame; sampled only in IDLE
abort  in  1  synchronous soft cancel; returns to IDLE next cycle, no done
valid_in  in  1  upstream tap data valid
in_ready  out  1  controller accepts a tap this cycle
mac_en  out  1  MAC accumulate enable = valid_in & in_ready (combinational)
acc_clear  out  1  accumulator clear-and-load; = mac_en & (tap_idx==0)
tap_idx  out  clog2(K*K) (min 1)  index of the current tap, 0..K*K-1
out_valid  out  1  accumulated result for (out_row,out_col) is valid
out_ready  in  1  downstream accepts the result
out_row  out  clog2(IMG_H-K+1) (min 1)  output row of the current window
out_col  out  clog2(IMG_W-K+1) (min 1)  output column of the current window
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the final window handshake

Behaviour:
- Reset (rst_n low, any time, including mid-frame): state=IDLE; tap_idx, out_row, out_col and the drain counter = 0; in_ready, out_valid, busy and done = 0. mac_en and acc_clear are therefore 0.
- States: IDLE, ACCUM, DRAIN, OUTPUT, DONE. in_ready, out_valid, busy and done decode from the state register only.
- IDLE: start=1 -> ACCUM; tap_idx, row and col cleared.
- ACCUM: in_ready=1. Each cycle with valid_in=1, tap_idx increments. When tap_idx==K*K-1 is accepted, tap_idx wraps to 0 and the state goes to DRAIN, or to OUTPUT if MAC_LAT==0. valid_in=0 stalls with no change.
- DRAIN: in_ready=0; stays exactly MAC_LAT cycles, then goes to OUTPUT.
- Latency: last tap accepted at edge T -> out_valid high from cycle T+1+MAC_LAT.
- OUTPUT: out_valid=1, and out_row/out_col stay stable until out_ready=1.
  - On handshake, if the window is not the last: col increments; at col==IMG_W-K, col wraps to 0 and row increments; state -> ACCUM.
  - On handshake of the last window (row==IMG_H-K and col==IMG_W-K): state -> DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE; row and col clear to 0.
- Windows per frame = (IMG_H-K+1)*(IMG_W-K+1); taps per frame = windows*K*K.
- start while busy: ignored; no restart and no state change.
- abort=1 in any non-IDLE state: next state IDLE, all counters cleared, done not pulsed. abort has priority over every other transition, including a same-cycle handshake. abort in IDLE has no effect.
- Simultaneous start and abort in IDLE: abort wins, stays IDLE.
- out_ready high outside OUTPUT: ignored. valid_in outside ACCUM: ignored, no mac_en.
- Counters never exceed their terminal values; no wrap beyond the frame.

Test Plan:
- Nominal frame, IMG_W=IMG_H=5, K=3, MAC_LAT=2, valid_in and out_ready tied 1 after start -> 9 out_valid handshakes in order (0,0),(0,1),(0,2),(1,0)..(2,2); 81 mac_en cycles; 9 acc_clear pulses; done pulses once; busy falls the cycle after done.
- Latency: last tap accepted at cycle 10 of the first window, MAC_LAT=2 -> out_valid first high at cycle 13; also run MAC_LAT=0 -> out_valid at cycle 11.
- Backpressure: hold out_ready=0 for 5 cycles on window (1,1) -> out_valid stays 1, row/col stay (1,1), in_ready=0, no mac_en; releasing it advances to (1,2).
- Input bubbles: valid_in toggling 1,0,1,0 -> tap_idx advances only on valid cycles; acc_clear only on the tap-0 beat; the result count is unchanged.
- Abort mid-window (tap_idx=4, window (0,2)) -> IDLE next cycle, busy=0, no done, counters 0. A following start runs a full 9-window frame.
- Async reset asserted during DRAIN -> all outputs 0 immediately without a clock edge. Also: start pulsed during ACCUM is ignored, and start+abort together in IDLE stays IDLE.
